// File: rtl/web1_wake_sequencer.sv
// web1 wake/event sequencer: synchronises and qualifies wake sources, keeps a sticky
// pending vector and runs the low-power entry/exit 4-phase handshakes with the PMU.
module web1_wake_sequencer #(
  parameter int N_SRC       = 64,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] wake_src,
  input  logic [N_SRC-1:0] wake_en,
  input  logic [N_SRC-1:0] wake_invert,
  input  logic [N_SRC-1:0] wake_pend_clr,
  input  logic [1:0]       ctrl_activate_low_pwr_edge,
  input  logic [1:0]       ctrl_event_suppress_edge,
  input  logic [1:0]       ctrl_wake_now_edge,
  input  logic [1:0]       ctrl_epu_enable_edge,
  output logic             event_activate_low_pwr_d,
  output logic             event_activate_low_pwr_enb,
  output logic             event_event_suppress_d,
  output logic             event_event_suppress_enb,
  output logic             event_wake_now_d,
  output logic             event_wake_now_enb,
  output logic             event_epu_enable_d,
  output logic             event_epu_enable_enb,
  output logic             pmu_lp_req,
  input  logic             pmu_lp_ack,
  output logic             pmu_wake_req,
  input  logic             pmu_wake_ack,
  output logic [N_SRC-1:0] wake_pending,
  output logic [ID_W-1:0]  wake_id,
  output logic             wake_irq,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_DISABLED = 3'd0,
    S_ACTIVE   = 3'd1,
    S_LP_ENTER = 3'd2,
    S_LOW_PWR  = 3'd3,
    S_LP_EXIT  = 3'd4
  } state_e;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] lvl;
  logic [N_SRC-1:0] lvl_q;
  logic             armed_q;
  logic [N_SRC-1:0] qual_edge;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  id_d;
  logic             epu_en_q;
  logic             epu_en_d;
  logic             suppress_q;
  logic             suppress_d;
  logic             trig;
  logic             lp_set;
  logic             now_set;

  state_e           state_q;
  logic             lp_req_q;
  logic             wake_req_q;
  logic             exit_now_q;
  logic             stb_epu_q;
  logic             stb_supp_q;
  logic             stb_lp_q;
  logic             stb_now_q;

  // Edge detection is only armed one cycle after reset so the first load of lvl_q
  // (e.g. an inverted idle-low source) never reads as a rising edge.
  assign lvl       = sync_q[SYNC_STAGES-1] ^ wake_invert;
  assign qual_edge = armed_q ? (lvl & ~lvl_q & wake_en) : '0;
  assign pending_d = (pending_q & ~wake_pend_clr) | qual_edge;

  always_comb begin
    epu_en_d = epu_en_q;
    case (ctrl_epu_enable_edge)
      2'b10:   epu_en_d = 1'b1;
      2'b01:   epu_en_d = 1'b0;
      default: epu_en_d = epu_en_q;
    endcase
  end

  always_comb begin
    suppress_d = suppress_q;
    case (ctrl_event_suppress_edge)
      2'b10:   suppress_d = 1'b1;
      2'b01:   suppress_d = 1'b0;
      default: suppress_d = suppress_q;
    endcase
  end

  always_comb begin
    id_d = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending_q[i]) id_d = ID_W'(i);
    end
  end

  assign trig    = (|pending_q) & ~suppress_q;
  assign lp_set  = ctrl_activate_low_pwr_edge[1];
  assign now_set = ctrl_wake_now_edge[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      lvl_q      <= '0;
      armed_q    <= 1'b0;
      pending_q  <= '0;
      id_q       <= '0;
      epu_en_q   <= 1'b0;
      suppress_q <= 1'b0;
    end else begin
      sync_q[0] <= wake_src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      lvl_q      <= lvl;
      armed_q    <= 1'b1;
      pending_q  <= pending_d;
      id_q       <= id_d;
      epu_en_q   <= epu_en_d;
      suppress_q <= suppress_d;
    end
  end

  // PMU handshakes are 4-phase: req rises, holds until ack=1, then drops; the
  // sequence completes only once ack has returned to 0. Neither side ever
  // abandons a phase; only rst may cut a handshake short.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_DISABLED;
      lp_req_q   <= 1'b0;
      wake_req_q <= 1'b0;
      exit_now_q <= 1'b0;
      stb_epu_q  <= 1'b0;
      stb_supp_q <= 1'b0;
      stb_lp_q   <= 1'b0;
      stb_now_q  <= 1'b0;
    end else begin
      stb_epu_q  <= 1'b0;
      stb_lp_q   <= 1'b0;
      stb_now_q  <= 1'b0;
      stb_supp_q <= suppress_q & (|qual_edge);
      case (state_q)
        S_DISABLED: begin
          if (epu_en_q) begin
            state_q   <= S_ACTIVE;
            stb_epu_q <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (!epu_en_q) begin
            state_q   <= S_DISABLED;
            stb_epu_q <= 1'b1;
          end else if (lp_set && !trig) begin
            state_q  <= S_LP_ENTER;
            lp_req_q <= 1'b1;
          end
        end
        S_LP_ENTER: begin
          if (lp_req_q) begin
            if (pmu_lp_ack) lp_req_q <= 1'b0;
          end else if (!pmu_lp_ack) begin
            state_q  <= S_LOW_PWR;
            stb_lp_q <= 1'b1;
          end
        end
        S_LOW_PWR: begin
          if (trig || now_set) begin
            state_q    <= S_LP_EXIT;
            wake_req_q <= 1'b1;
            exit_now_q <= now_set;
          end
        end
        S_LP_EXIT: begin
          if (wake_req_q) begin
            if (pmu_wake_ack) wake_req_q <= 1'b0;
          end else if (!pmu_wake_ack) begin
            state_q    <= S_ACTIVE;
            stb_now_q  <= exit_now_q;
            exit_now_q <= 1'b0;
          end
        end
        default: state_q <= S_DISABLED;
      endcase
    end
  end

  // Requests are gated by rst so a reset mid-handshake drops them immediately.
  assign pmu_lp_req   = lp_req_q & ~rst;
  assign pmu_wake_req = wake_req_q & ~rst;

  assign event_activate_low_pwr_d   = stb_lp_q;
  assign event_activate_low_pwr_enb = stb_lp_q;
  assign event_event_suppress_d     = stb_supp_q;
  assign event_event_suppress_enb   = stb_supp_q;
  assign event_wake_now_d           = stb_now_q;
  assign event_wake_now_enb         = stb_now_q;
  assign event_epu_enable_d         = stb_epu_q;
  assign event_epu_enable_enb       = stb_epu_q;

  assign wake_pending = pending_q;
  assign wake_id      = id_q;
  assign wake_irq     = trig;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_web1_wake_sequencer.sv
// Self-checking bench for web1_wake_sequencer: directed FSM/handshake scenarios plus
// randomized source activity compared against a delay-line reference model.
module tb_web1_wake_sequencer;

  localparam int N = 64;
  localparam int SYNC = 2;
  localparam logic [2:0] ST_DISABLED = 3'd0, ST_ACTIVE = 3'd1, ST_LP_ENTER = 3'd2,
                         ST_LOW_PWR = 3'd3, ST_LP_EXIT = 3'd4;

  logic clk, rst;
  logic [N-1:0] wake_src, wake_en, wake_invert, wake_pend_clr;
  logic [1:0] ctrl_alp, ctrl_sup, ctrl_wn, ctrl_epu;
  logic alp_d, alp_enb, sup_d, sup_enb, wn_d, wn_enb, epu_d, epu_enb;
  logic pmu_lp_req, pmu_lp_ack, pmu_wake_req, pmu_wake_ack;
  logic [N-1:0] wake_pending;
  logic [5:0] wake_id;
  logic wake_irq;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;

  web1_wake_sequencer #(.N_SRC(N), .SYNC_STAGES(SYNC), .ID_W(6)) dut (
    .clk(clk), .rst(rst),
    .wake_src(wake_src), .wake_en(wake_en), .wake_invert(wake_invert),
    .wake_pend_clr(wake_pend_clr),
    .ctrl_activate_low_pwr_edge(ctrl_alp), .ctrl_event_suppress_edge(ctrl_sup),
    .ctrl_wake_now_edge(ctrl_wn), .ctrl_epu_enable_edge(ctrl_epu),
    .event_activate_low_pwr_d(alp_d), .event_activate_low_pwr_enb(alp_enb),
    .event_event_suppress_d(sup_d), .event_event_suppress_enb(sup_enb),
    .event_wake_now_d(wn_d), .event_wake_now_enb(wn_enb),
    .event_epu_enable_d(epu_d), .event_epu_enable_enb(epu_enb),
    .pmu_lp_req(pmu_lp_req), .pmu_lp_ack(pmu_lp_ack),
    .pmu_wake_req(pmu_wake_req), .pmu_wake_ack(pmu_wake_ack),
    .wake_pending(wake_pending), .wake_id(wake_id), .wake_irq(wake_irq),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  // Reference model: the level seen by the block is the source as sampled SYNC edges
  // earlier, XOR the current invert mask; a rising seen-level on an enabled source sets
  // its pending bit, clear loses to set, wake_id is the lowest pending index one edge late.
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_pend, m_lvl_prev, m_seen, m_rise;
  logic [5:0]   m_id;
  logic         m_supp, m_supp_stb, m_armed;

  function automatic logic [5:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 6'(i);
    return 6'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
      m_pend = '0; m_id = '0; m_supp = 1'b0; m_supp_stb = 1'b0;
      m_armed = 1'b0; m_lvl_prev = '0;
    end else begin
      m_id = lowest(m_pend);
      m_seen = m_hist.pop_front() ^ wake_invert;
      m_rise = m_armed ? (m_seen & ~m_lvl_prev & wake_en) : '0;
      m_supp_stb = (|m_rise) && m_supp;
      m_pend = (m_pend & ~wake_pend_clr) | m_rise;
      m_lvl_prev = m_seen;
      m_armed = 1'b1;
      m_hist.push_back(wake_src);
      if (ctrl_sup == 2'b10) m_supp = 1'b1;
      else if (ctrl_sup == 2'b01) m_supp = 1'b0;
    end
  end

  // Driver tasks: inputs change 2 time units after the active edge; checks follow.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int which, input logic [1:0] v);
    case (which)
      0: ctrl_alp = v;
      1: ctrl_sup = v;
      2: ctrl_wn = v;
      default: ctrl_epu = v;
    endcase
    tick();
    ctrl_alp = 2'b00; ctrl_sup = 2'b00; ctrl_wn = 2'b00; ctrl_epu = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wake_src = '0; wake_en = '1; wake_invert = 64'h20; wake_pend_clr = '0;
    ctrl_alp = 2'b00; ctrl_sup = 2'b00; ctrl_wn = 2'b00; ctrl_epu = 2'b00;
    pmu_lp_ack = 1'b0; pmu_wake_ack = 1'b0;
    ticks(3);
    checks++;
    if ({alp_d, alp_enb, sup_d, sup_enb, wn_d, wn_enb, epu_d, epu_enb, pmu_lp_req,
         pmu_wake_req, wake_irq} !== 11'b0) begin
      failures++; $display("FAIL reset_outputs got nonzero strobe/req/irq exp=0");
    end
    checks++;
    if (wake_pending !== '0 || wake_id !== 6'd0 || dbg_state !== ST_DISABLED) begin
      failures++;
      $display("FAIL reset_state got pend=%h id=%0d st=%0d exp 0/0/0", wake_pending, wake_id, dbg_state);
    end
    rst = 1'b0;
    ticks(5);
    checks++;
    if (wake_pending !== '0) begin
      failures++; $display("FAIL reset_no_false_edge got=%h exp=0", wake_pending);
    end
  endtask

  task automatic test_epu_enable();
    pulse(3, 2'b10);
    checks++;
    if (dbg_state !== ST_DISABLED || epu_d !== 1'b0) begin
      failures++; $display("FAIL epu_first_cycle got st=%0d stb=%b exp st=0 stb=0", dbg_state, epu_d);
    end
    tick();
    checks++;
    if (dbg_state !== ST_ACTIVE || {epu_d, epu_enb} !== 2'b11) begin
      failures++; $display("FAIL epu_strobe got st=%0d stb=%b%b exp st=1 stb=11", dbg_state, epu_d, epu_enb);
    end
    tick();
    checks++;
    if (epu_d !== 1'b0) begin
      failures++; $display("FAIL epu_strobe_width got=%b exp=0", epu_d);
    end
    pulse(3, 2'b11);
    ticks(2);
    checks++;
    if (dbg_state !== ST_ACTIVE || epu_d !== 1'b0) begin
      failures++; $display("FAIL epu_both_hold got st=%0d stb=%b exp st=1 stb=0", dbg_state, epu_d);
    end
  endtask

  task automatic test_latency();
    wake_src[37] = 1'b1;
    ticks(2);
    checks++;
    if (wake_pending[37] !== 1'b0) begin
      failures++; $display("FAIL latency_early got=%b exp=0", wake_pending[37]);
    end
    tick();
    checks++;
    if (wake_pending[37] !== 1'b1 || wake_irq !== 1'b1 || wake_id !== 6'd0) begin
      failures++;
      $display("FAIL latency_set got pend=%b irq=%b id=%0d exp 1/1/0", wake_pending[37], wake_irq, wake_id);
    end
    tick();
    checks++;
    if (wake_id !== 6'd37) begin
      failures++; $display("FAIL wake_id_37 got=%0d exp=37", wake_id);
    end
  endtask

  task automatic test_invert();
    wake_src[5] = 1'b1;
    ticks(4);
    checks++;
    if (wake_pending[5] !== 1'b0) begin
      failures++; $display("FAIL invert_rising_input got=%b exp=0", wake_pending[5]);
    end
    wake_src[5] = 1'b0;
    ticks(3);
    checks++;
    if (wake_pending[5] !== 1'b1) begin
      failures++; $display("FAIL invert_falling_input got=%b exp=1", wake_pending[5]);
    end
    tick();
    checks++;
    if (wake_id !== 6'd5) begin
      failures++; $display("FAIL wake_id_5 got=%0d exp=5", wake_id);
    end
  endtask

  task automatic test_clr_collision();
    wake_src[37] = 1'b0;
    ticks(4);
    wake_src[37] = 1'b1;
    ticks(2);
    wake_pend_clr[37] = 1'b1;
    tick();
    wake_pend_clr = '0;
    checks++;
    if (wake_pending[37] !== 1'b1) begin
      failures++; $display("FAIL clr_collision got=%b exp=1", wake_pending[37]);
    end
    wake_pend_clr[37] = 1'b1;
    tick();
    wake_pend_clr = '0;
    checks++;
    if (wake_pending[37] !== 1'b0 || wake_pending[5] !== 1'b1) begin
      failures++; $display("FAIL clr_alone got p37=%b p5=%b exp 0/1", wake_pending[37], wake_pending[5]);
    end
    wake_pend_clr[5] = 1'b1;
    tick();
    wake_pend_clr = '0;
    checks++;
    if (wake_pending !== '0 || wake_irq !== 1'b0) begin
      failures++; $display("FAIL clr_all got=%h irq=%b exp=0", wake_pending, wake_irq);
    end
  endtask

  task automatic test_lp_sequence();
    pulse(0, 2'b10);
    checks++;
    if (dbg_state !== ST_LP_ENTER || pmu_lp_req !== 1'b1) begin
      failures++; $display("FAIL lp_req_rise got st=%0d req=%b exp 2/1", dbg_state, pmu_lp_req);
    end
    ticks(3);
    checks++;
    if (pmu_lp_req !== 1'b1 || dbg_state !== ST_LP_ENTER) begin
      failures++; $display("FAIL lp_req_hold got st=%0d req=%b exp 2/1", dbg_state, pmu_lp_req);
    end
    pmu_lp_ack = 1'b1;
    tick();
    checks++;
    if (pmu_lp_req !== 1'b0 || dbg_state !== ST_LP_ENTER) begin
      failures++; $display("FAIL lp_req_drop got st=%0d req=%b exp 2/0", dbg_state, pmu_lp_req);
    end
    pmu_lp_ack = 1'b0;
    tick();
    checks++;
    if (dbg_state !== ST_LOW_PWR || {alp_d, alp_enb} !== 2'b11) begin
      failures++; $display("FAIL lp_enter_done got st=%0d stb=%b%b exp 3/11", dbg_state, alp_d, alp_enb);
    end
    wake_src[0] = 1'b1;
    ticks(3);
    checks++;
    if (wake_pending[0] !== 1'b1 || dbg_state !== ST_LOW_PWR || pmu_wake_req !== 1'b0 || alp_d !== 1'b0) begin
      failures++;
      $display("FAIL lp_wake_pending got p0=%b st=%0d wreq=%b exp 1/3/0", wake_pending[0], dbg_state, pmu_wake_req);
    end
    tick();
    checks++;
    if (dbg_state !== ST_LP_EXIT || pmu_wake_req !== 1'b1) begin
      failures++; $display("FAIL lp_exit_req got st=%0d wreq=%b exp 4/1", dbg_state, pmu_wake_req);
    end
    pmu_wake_ack = 1'b1;
    tick();
    pmu_wake_ack = 1'b0;
    checks++;
    if (pmu_wake_req !== 1'b0 || dbg_state !== ST_LP_EXIT) begin
      failures++; $display("FAIL lp_exit_drop got st=%0d wreq=%b exp 4/0", dbg_state, pmu_wake_req);
    end
    tick();
    checks++;
    if (dbg_state !== ST_ACTIVE || wake_irq !== 1'b1 || wn_d !== 1'b0) begin
      failures++; $display("FAIL lp_exit_done got st=%0d irq=%b wn=%b exp 1/1/0", dbg_state, wake_irq, wn_d);
    end
    wake_pend_clr[0] = 1'b1;
    tick();
    wake_pend_clr = '0;
  endtask

  task automatic test_suppress_lp();
    pulse(0, 2'b10);
    pmu_lp_ack = 1'b1;
    tick();
    pmu_lp_ack = 1'b0;
    tick();
    pulse(1, 2'b10);
    checks++;
    if (dbg_state !== ST_LOW_PWR) begin
      failures++; $display("FAIL sup_enter got st=%0d exp=3", dbg_state);
    end
    wake_src[63] = 1'b1;
    ticks(3);
    checks++;
    if (wake_pending[63] !== 1'b1 || {sup_d, sup_enb} !== 2'b11 || wake_irq !== 1'b0) begin
      failures++;
      $display("FAIL sup_edge got p63=%b stb=%b%b irq=%b exp 1/11/0", wake_pending[63], sup_d, sup_enb, wake_irq);
    end
    ticks(3);
    checks++;
    if (dbg_state !== ST_LOW_PWR || pmu_wake_req !== 1'b0 || sup_d !== 1'b0) begin
      failures++; $display("FAIL sup_blocks_exit got st=%0d wreq=%b stb=%b exp 3/0/0", dbg_state, pmu_wake_req, sup_d);
    end
    pulse(2, 2'b10);
    checks++;
    if (dbg_state !== ST_LP_EXIT || pmu_wake_req !== 1'b1) begin
      failures++; $display("FAIL wake_now_exit got st=%0d wreq=%b exp 4/1", dbg_state, pmu_wake_req);
    end
    pmu_wake_ack = 1'b1;
    tick();
    pmu_wake_ack = 1'b0;
    tick();
    checks++;
    if (dbg_state !== ST_ACTIVE || {wn_d, wn_enb} !== 2'b11) begin
      failures++; $display("FAIL wake_now_strobe got st=%0d stb=%b%b exp 1/11", dbg_state, wn_d, wn_enb);
    end
    pulse(2, 2'b10);
    tick();
    checks++;
    if (dbg_state !== ST_ACTIVE || wn_d !== 1'b0 || pmu_wake_req !== 1'b0) begin
      failures++; $display("FAIL wake_now_ignored got st=%0d stb=%b exp 1/0", dbg_state, wn_d);
    end
  endtask

  task automatic test_lp_blocked();
    pulse(1, 2'b01);
    checks++;
    if (wake_irq !== 1'b1) begin
      failures++; $display("FAIL unsuppress_irq got=%b exp=1", wake_irq);
    end
    pulse(0, 2'b10);
    tick();
    checks++;
    if (dbg_state !== ST_ACTIVE || pmu_lp_req !== 1'b0 || alp_d !== 1'b0) begin
      failures++; $display("FAIL lp_blocked got st=%0d req=%b exp 1/0", dbg_state, pmu_lp_req);
    end
    wake_pend_clr[63] = 1'b1;
    tick();
    wake_pend_clr = '0;
  endtask

  task automatic test_deferred_disable();
    pulse(0, 2'b10);
    pulse(3, 2'b01);
    checks++;
    if (dbg_state !== ST_LP_ENTER || epu_d !== 1'b0) begin
      failures++; $display("FAIL defer_hold got st=%0d stb=%b exp 2/0", dbg_state, epu_d);
    end
    pmu_lp_ack = 1'b1;
    tick();
    pmu_lp_ack = 1'b0;
    tick();
    pulse(2, 2'b10);
    pmu_wake_ack = 1'b1;
    tick();
    pmu_wake_ack = 1'b0;
    tick();
    checks++;
    if (dbg_state !== ST_ACTIVE || epu_d !== 1'b0) begin
      failures++; $display("FAIL defer_active got st=%0d stb=%b exp 1/0", dbg_state, epu_d);
    end
    tick();
    checks++;
    if (dbg_state !== ST_DISABLED || {epu_d, epu_enb} !== 2'b11) begin
      failures++; $display("FAIL defer_disable got st=%0d stb=%b%b exp 0/11", dbg_state, epu_d, epu_enb);
    end
    pulse(3, 2'b10);
    tick();
    checks++;
    if (dbg_state !== ST_ACTIVE) begin
      failures++; $display("FAIL reenable got st=%0d exp=1", dbg_state);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 1) == 0) wake_src[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0) wake_src[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) wake_invert[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) wake_en[$urandom_range(0, N-1)] ^= 1'b1;
      wake_pend_clr = '0;
      if ($urandom_range(0, 2) == 0) wake_pend_clr[$urandom_range(0, N-1)] = 1'b1;
      if ($urandom_range(0, 7) == 0) wake_pend_clr = m_pend & {N{1'b1}} & (64'h1 << lowest(m_pend));
      ctrl_sup = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      tick();
      checks++;
      if (wake_pending !== m_pend) begin
        failures++; $display("FAIL rand_pending cyc=%0d got=%h exp=%h", cyc, wake_pending, m_pend);
      end
      checks++;
      if (wake_id !== m_id) begin
        failures++; $display("FAIL rand_wake_id cyc=%0d got=%0d exp=%0d", cyc, wake_id, m_id);
      end
      checks++;
      if (wake_irq !== ((|m_pend) & ~m_supp)) begin
        failures++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", cyc, wake_irq, (|m_pend) & ~m_supp);
      end
      checks++;
      if (sup_d !== m_supp_stb || sup_enb !== m_supp_stb) begin
        failures++; $display("FAIL rand_sup_strobe cyc=%0d got=%b exp=%b", cyc, sup_d, m_supp_stb);
      end
    end
    ctrl_sup = 2'b00;
    wake_pend_clr = '0;
    wake_en = '1;
  endtask

  task automatic test_rst_mid_handshake();
    pulse(1, 2'b10);
    pulse(0, 2'b10);
    checks++;
    if (dbg_state !== ST_LP_ENTER || pmu_lp_req !== 1'b1) begin
      failures++; $display("FAIL rst_mid_setup got st=%0d req=%b exp 2/1", dbg_state, pmu_lp_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pmu_lp_req !== 1'b0) begin
      failures++; $display("FAIL rst_req_same_cycle got=%b exp=0", pmu_lp_req);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (dbg_state !== ST_DISABLED || pmu_lp_req !== 1'b0 || wake_pending !== '0) begin
      failures++; $display("FAIL rst_mid_state got st=%0d req=%b pend=%h exp 0/0/0", dbg_state, pmu_lp_req, wake_pending);
    end
  endtask

  initial begin
    test_reset();
    test_epu_enable();
    test_latency();
    test_invert();
    test_clr_collision();
    test_lp_sequence();
    test_suppress_lp();
    test_lp_blocked();
    test_deferred_disable();
    test_random();
    test_rst_mid_handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/web1_wake_sequencer.md
Name: web1_wake_sequencer

Overview:
Wake-event sequencer for the web1 wake/event block. It synchronises N_SRC asynchronous wake sources and applies the software invert and enable masks. It latches qualified rising edges into a sticky pending vector. It runs the low-power entry/exit handshake with the PMU, driven by the web1 control register edge pulses, and reports completions through the event register hardware-set path (d/enb).

Parameters:
N_SRC, 64, number of wake sources (wake_enable0/1 and input_invert0/1 concatenated, bit 0 = register 0 bit 0)
SYNC_STAGES, 2, synchroniser depth for wake_src (minimum 2)
ID_W, 6, width of wake_id; must equal clog2(N_SRC)

Ports:
clk  in  1  block clock
rst  in  1  synchronous reset, active-high
wake_src  in  N_SRC  asynchronous wake inputs
wake_en  in  N_SRC  per-source enable (wake_enable*.enable_q)
wake_invert  in  N_SRC  per-source polarity invert (input_invert*.invert_q)
wake_pend_clr  in  N_SRC  write-one-to-clear pulses for pending bits
ctrl_activate_low_pwr_edge, ctrl_event_suppress_edge, ctrl_wake_now_edge, ctrl_epu_enable_edge  in  2 each  [1] = one-cycle set pulse, [0] = one-cycle clear pulse
event_activate_low_pwr_d/_enb, event_event_suppress_d/_enb, event_wake_now_d/_enb, event_epu_enable_d/_enb  out  1 each  hardware-set strobes into the event register
pmu_lp_req  out  1  low-power entry request (4-phase)
pmu_lp_ack  in  1  PMU entry acknowledge
pmu_wake_req  out  1  wake request (4-phase)
pmu_wake_ack  in  1  PMU wake acknowledge
wake_pending  out  N_SRC  sticky pending vector
wake_id  out  ID_W  lowest-index pending bit, registered; 0 when none pending
wake_irq  out  1  |wake_pending AND NOT suppress

Behaviour:
- Reset: all outputs 0; state DISABLED; epu_en = 0, suppress = 0; synchronisers and pending cleared.
- Source qualification: lvl = sync(wake_src) XOR wake_invert.
  - Qualified edge = lvl rising AND wake_en.
  - The edge-detect register loads without comparing in the first cycle after rst deasserts, so no false edges occur.
  - Toggling wake_invert while enabled can create an edge; that edge counts.
- Pending latency: a bit sets SYNC_STAGES+1 clocks after the first clk sampling the new source level.
- Pending update: set on a qualified edge, cleared by wake_pend_clr. If set and clear hit the same bit in the same cycle, set wins. Pending latches regardless of FSM state and suppress.
- Enable and suppress flags:
  - epu_en and suppress: [1] sets, [0] clears. If both bits arrive in one cycle, the flag holds its value.
  - suppress blocks wake_irq and blocks exit from LOW_PWR. It does not block latching.
- Event strobes: d = 1 and enb = 1 for exactly one cycle per event.
  - epu_enable: on every epu_en change that takes effect.
  - event_suppress: on a qualified edge while suppress = 1.
  - activate_low_pwr: on entry to LOW_PWR.
  - wake_now: on return to ACTIVE from an exit caused by wake_now.
- Definition: trig = |wake_pending AND NOT suppress.
- FSM:
  - DISABLED: epu_en = 1 -> ACTIVE.
  - ACTIVE:
    - epu_en = 0 -> DISABLED.
    - activate_low_pwr [1] pulse with trig = 0 -> LP_ENTER, pmu_lp_req = 1 the next cycle.
    - That pulse while trig = 1 is dropped; state stays ACTIVE; no strobe.
  - LP_ENTER: hold pmu_lp_req until pmu_lp_ack = 1, then drop req. When ack returns to 0 -> LOW_PWR. A wake during LP_ENTER is remembered and acted on in LOW_PWR.
  - LOW_PWR: trig = 1 or a wake_now [1] pulse -> LP_EXIT.
  - LP_EXIT: hold pmu_wake_req until pmu_wake_ack = 1, then drop req. When ack returns to 0 -> ACTIVE.
  - No 4-phase handshake is ever abandoned mid-sequence.
  - epu_en clearing outside ACTIVE/DISABLED is deferred: the FSM goes to DISABLED on its next ACTIVE cycle and the epu_enable strobe fires then.
  - wake_now pulses outside LOW_PWR are ignored.
  - activate_low_pwr [0] pulses are ignored.
- wake_id: a priority encoder, registered, so it lags wake_pending by 1 cycle.
- rst mid-handshake: req drops in the same cycle and the FSM returns to DISABLED. The PMU tolerates this.

Test Plan:
- Reset -> all outputs 0. Set epu_en -> state ACTIVE; epu_enable strobe for 1 cycle. Raise wake_src[37] with wake_en[37] = 1 -> wake_pending[37] = 1 after SYNC_STAGES+1 = 3 clocks; wake_id = 37 one clock later; wake_irq = 1.
- wake_invert[5] = 1, wake_en[5] = 1, wake_src[5] held 0 through reset -> no pending after reset. Drive wake_src[5] 0 -> 1 -> 0 -> pending[5] sets on the falling input.
- Pend_clr collision: wake_pend_clr[37] in the same cycle a new edge sets bit 37 -> bit stays 1. Clear alone -> bit 0 next cycle.
- Full sequence, no pending: activate_low_pwr set pulse -> pmu_lp_req; PMU acks after 4 cycles -> LOW_PWR; activate_low_pwr strobe. Edge on source 0 -> pmu_wake_req; PMU ack -> ACTIVE; wake_irq = 1.
- Suppress in LOW_PWR: suppress = 1, then an edge on source 63 -> pending[63] = 1, event_suppress strobe, no pmu_wake_req. wake_now pulse -> exit; wake_now strobe on return to ACTIVE.
- activate_low_pwr pulse with pending nonzero and suppress = 0 -> no pmu_lp_req. rst asserted during LP_ENTER with req high -> req 0 in the same cycle; state DISABLED.
